// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive front end: FSM state encodings and bit-timing counts.
package uart_rx_fifo_pkg;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t ST_IDLE  = 2'd0;
    localparam rx_state_t ST_START = 2'd1;
    localparam rx_state_t ST_DATA  = 2'd2;
    localparam rx_state_t ST_STOP  = 2'd3;

    localparam int MID_TICK  = 7;
    localparam int BIT_TICKS = 16;
    localparam int DATA_BITS = 8;

    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// First-word-fall-through byte FIFO with registered flags and a sticky overflow indicator.
module rx_byte_fifo #(
    parameter int FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       overflow_o
);

    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0]         mem_q [2**FIFO_AW];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               empty_q, full_q, overflow_q, overflow_d;
    logic               do_push, do_pop;

    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    assign do_pop  = pop_i & ~empty_q;
    assign do_push = push_i & (~full_q | do_pop);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_i & ~do_push);
        if (do_push) wptr_d = wptr_q + FIFO_AW'(1);
        if (do_pop)  rptr_d = rptr_q + FIFO_AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (FIFO_AW+1)'(1);
        else if (!do_push && do_pop) count_d = count_q - (FIFO_AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == FULL_CNT);
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    assign dout_o     = empty_q ? 8'h00 : mem_q[rptr_q];
    assign empty_o    = empty_q;
    assign full_o     = full_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled 8N1 UART receiver feeding an FWFT byte FIFO.
// Define RX_FRAME_ERR_EN to drop frames with a bad stop bit and expose o_frame_err.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_AW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       i_pop,
    output logic [7:0] rx_fifo_data,
    output logic       o_rx_empty,
    output logic       o_rx_full,
    output logic       o_overflow
`ifdef RX_FRAME_ERR_EN
    ,
    output logic       o_frame_err
`endif
);

    localparam int                DIV       = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int                DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]        MID_CNT   = 4'(MID_TICK);
    localparam logic [3:0]        LAST_TICK = 4'(BIT_TICKS - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    logic             rx_meta_q, rx_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    rx_state_t        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_q, push_d;
    logic             start_ok;

`ifdef RX_FRAME_ERR_EN
    logic             ferr_q, ferr_d;
    logic             wait_hi_q, wait_hi_d;

    // After a framing error the line must return high before a new start bit is trusted.
    assign start_ok    = ~wait_hi_q;
    assign o_frame_err = ferr_q;
`else
    assign start_ok    = 1'b1;
`endif

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push_d  = 1'b0;
`ifdef RX_FRAME_ERR_EN
        ferr_d    = 1'b0;
        wait_hi_d = wait_hi_q & ~rx_sync_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_sync_q && start_ok) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (cnt_q == MID_CNT) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (cnt_q == LAST_TICK) begin
                        cnt_d   = '0;
                        shift_d = {rx_sync_q, shift_q[7:1]};
                        if (bit_q == LAST_BIT) state_d = ST_STOP;
                        else                   bit_d   = bit_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (cnt_q == LAST_TICK) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
`ifdef RX_FRAME_ERR_EN
                        if (rx_sync_q) begin
                            push_d = 1'b1;
                        end else begin
                            ferr_d    = 1'b1;
                            wait_hi_d = 1'b1;
                        end
`else
                        push_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            div_q     <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            push_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            div_q     <= div_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            push_q    <= push_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

`ifdef RX_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            ferr_q    <= 1'b0;
            wait_hi_q <= 1'b0;
        end else begin
            ferr_q    <= ferr_d;
            wait_hi_q <= wait_hi_d;
        end
    end
`endif

    rx_byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_q),
        .din_i      (shift_q),
        .pop_i      (i_pop),
        .dout_o     (rx_fifo_data),
        .empty_o    (o_rx_empty),
        .full_o     (o_rx_full),
        .overflow_o (o_overflow)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, corner sequences and a randomized run against a queue model.
module tb_uart_rx_fifo;

    // Divisor of 4 keeps a bit at 64 clocks so whole frames simulate quickly.
    localparam int BITC = 64;
`ifdef RX_FRAME_ERR_EN
    localparam bit FERR = 1'b1;
`else
    localparam bit FERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       man_pop;
    logic       auto_pop;
    logic       i_pop;
    logic [7:0] rx_fifo_data;
    logic       o_rx_empty;
    logic       o_rx_full;
    logic       o_overflow;
`ifdef RX_FRAME_ERR_EN
    logic       o_frame_err;
`endif

    assign i_pop = auto_pop ? ~o_rx_empty : man_pop;

    uart_rx_fifo #(
        .CLK_HZ     (614_400),
        .BAUD       (9600),
        .OVERSAMPLE (16),
        .FIFO_AW    (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .i_pop        (i_pop),
        .rx_fifo_data (rx_fifo_data),
        .o_rx_empty   (o_rx_empty),
        .o_rx_full    (o_rx_full),
        .o_overflow   (o_overflow)
`ifdef RX_FRAME_ERR_EN
        ,
        .o_frame_err  (o_frame_err)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         low_cycles;
    int         ferr_cycles;
    logic [7:0] last_seen;

    always @(negedge clk) begin
        if (!o_rx_empty) begin
            low_cycles = low_cycles + 1;
            last_seen  = rx_fifo_data;
        end
`ifdef RX_FRAME_ERR_EN
        if (o_frame_err) ferr_cycles = ferr_cycles + 1;
`endif
    end

    logic [7:0] mq[$];
    bit         m_ovf;

    typedef struct {
        logic [7:0] data;
        logic       exp_full;
        logic       exp_ovf;
        logic [7:0] exp_head;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // A zero stop bit is held for only 3/4 of a bit so the line is high again before a false start is qualified.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BITC) @(negedge clk);
        end
        rx = stop;
        repeat (stop ? BITC : (BITC * 3) / 4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk) man_pop = 1'b1;
        @(negedge clk) man_pop = 1'b0;
    endtask

    task automatic model_send(input logic [7:0] d, input logic stop);
        if (stop || !FERR) begin
            if (mq.size() < 8) mq.push_back(d);
            else               m_ovf = 1'b1;
        end
    endtask

    task automatic model_pop();
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic check_model(input string tag);
        check({tag, " empty"}, o_rx_empty, (mq.size() == 0));
        check({tag, " full"}, o_rx_full, (mq.size() == 8));
        check({tag, " overflow"}, o_overflow, m_ovf);
        check({tag, " head"}, rx_fifo_data, (mq.size() > 0) ? mq[0] : 8'h00);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       s;

        tbl[0] = '{8'h48, 1'b0, 1'b0, 8'h48};
        tbl[1] = '{8'h4D, 1'b0, 1'b0, 8'h48};
        tbl[2] = '{8'h53, 1'b0, 1'b0, 8'h48};
        tbl[3] = '{8'h63, 1'b0, 1'b0, 8'h48};
        tbl[4] = '{8'h6D, 1'b0, 1'b0, 8'h48};
        tbl[5] = '{8'h61, 1'b0, 1'b0, 8'h48};
        tbl[6] = '{8'h74, 1'b0, 1'b0, 8'h48};
        tbl[7] = '{8'h73, 1'b1, 1'b0, 8'h48};
        tbl[8] = '{8'h41, 1'b1, 1'b1, 8'h48};

        rst = 1'b0; rx = 1'b1; man_pop = 1'b0; auto_pop = 1'b0;
        low_cycles = 0; ferr_cycles = 0; last_seen = 8'h00; m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("reset empty", o_rx_empty, 1'b1);
        check("reset full", o_rx_full, 1'b0);
        check("reset overflow", o_overflow, 1'b0);
        check("reset data", rx_fifo_data, 8'h00);
`ifdef RX_FRAME_ERR_EN
        check("reset frame_err", o_frame_err, 1'b0);
`endif
        rst = 1'b1;

        repeat (1000) @(negedge clk);
        check_model("idle");

        auto_pop = 1'b1; low_cycles = 0;
        send_byte(8'h73, 1'b1);
        check("autopop low cycles", low_cycles, 1);
        check("autopop data", last_seen, 8'h73);
        check("autopop empty", o_rx_empty, 1'b1);
        auto_pop = 1'b0;

        for (int i = 0; i < 9; i++) begin
            send_byte(tbl[i].data, 1'b1);
            model_send(tbl[i].data, 1'b1);
            check($sformatf("fill%0d empty", i), o_rx_empty, 1'b0);
            check($sformatf("fill%0d full", i), o_rx_full, tbl[i].exp_full);
            check($sformatf("fill%0d overflow", i), o_overflow, tbl[i].exp_ovf);
            check($sformatf("fill%0d head", i), rx_fifo_data, tbl[i].exp_head);
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d head", i), rx_fifo_data, tbl[i].data);
            pop_one();
            model_pop();
        end
        check_model("drained");
        check("drained overflow held", o_overflow, 1'b1);
        pop_one();
        check_model("pop while empty");

        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mq.delete(); m_ovf = 1'b0;
        check("overflow cleared by reset", o_overflow, 1'b0);

        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch no push", o_rx_empty, 1'b1);

        rx = 1'b0;
        repeat (BITC * 3) @(negedge clk);
        rst = 1'b0; rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (800) @(negedge clk);
        check("midframe reset no push", o_rx_empty, 1'b1);

        ferr_cycles = 0;
        send_byte(8'h55, 1'b0);
        model_send(8'h55, 1'b0);
`ifdef RX_FRAME_ERR_EN
        check("frame_err pulse", ferr_cycles, 1);
`endif
        check_model("bad stop");
        while (mq.size() > 0) begin
            pop_one();
            model_pop();
        end
        check_model("bad stop drained");

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 6) begin
                repeat ($urandom_range(0, 7)) @(negedge clk);
                d = 8'($urandom_range(0, 255));
                s = ($urandom_range(0, 4) != 0);
                send_byte(d, s);
                model_send(d, s);
            end else begin
                pop_one();
                model_pop();
            end
            check_model($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
